gc_scheduler: RTL and testbench
===============================

GC_SCHEDULER -- requirements
Module: gc_scheduler

Interface
REQ-001 SHALL take parameters: NUM_BLK=64, number of NVM blocks; PG_PER_BLK=32, pages per block; FREE_LOW=4, free-block watermark below which GC is requested.
REQ-002 SHALL have ports: CLK in 1 clock; RST in 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports: gc_ini in 1 init pulse; gc_start in 1 GC grant from the overall controller; active_request in 1 host access pending.
REQ-004 SHALL have ports: invalid_flag in 1 page-invalidate strobe; invalid_blk in block_t invalidated block; move_done_flag in 1 valid-page relocation complete; erase_ack in 1 erase complete.
REQ-005 SHALL have ports: fifo_recover_en in 1 free FIFO popped; recover_blk in block_t popped block (becomes the open block).
REQ-006 SHALL have ports: gc_request out 1; gc_interrupt out 1; req_done out 1; move_flag out 1; active_blk out block_t victim; erase_flag out 1; erase_blk out block_t; free_push out 1; free_blk out block_t.

Function
REQ-007 SHALL keep per-block invalid count (width clog2(PG_PER_BLK+1)), per-block free bit, open-block register, and free_cnt (width clog2(NUM_BLK+1)).
REQ-008 SHALL implement FSM states IDLE, SCAN, MOVE, PAUSE, ERASE, DONE.
REQ-009 SHALL assert gc_request combinationally in IDLE when free_cnt < FREE_LOW.
REQ-010 IDLE->SCAN when gc_request and gc_start are both high.
REQ-011 SCAN SHALL examine one block per cycle, index 0..NUM_BLK-1, NUM_BLK cycles total; eligible = not free, not open block, count>0; best = highest count, ties to lowest index.
REQ-012 SCAN end: no eligible block -> DONE without erase; else latch victim, ->MOVE.
REQ-013 MOVE SHALL drive move_flag=1, active_blk=victim; move_done_flag -> ERASE.
REQ-014 active_request high in MOVE (move_done_flag low) -> PAUSE: gc_interrupt=1, move_flag=0; active_request low -> MOVE next cycle; move_done_flag high in MOVE takes priority over active_request.
REQ-015 ERASE SHALL hold erase_flag=1, erase_blk=victim until erase_ack; ->DONE.
REQ-016 DONE (one cycle) SHALL pulse req_done; if victim exists also pulse free_push with free_blk=victim, clear its count, set free bit, increment free_cnt; ->IDLE.
REQ-017 invalid_flag SHALL increment count of invalid_blk, saturating at PG_PER_BLK; same-cycle DONE clear of that block wins.
REQ-018 fifo_recover_en SHALL clear free bit of recover_blk, load open block, decrement free_cnt (no underflow); coincident with free_push, free_cnt unchanged.
REQ-019 gc_ini SHALL, from any state, return FSM to IDLE, set all free bits, clear counts, free_cnt=NUM_BLK, open block=0.

Reset
REQ-020 RST SHALL asynchronously force IDLE and all outputs 0, state as after gc_ini.
REQ-021 RST or gc_ini mid-operation SHALL abandon the victim with no req_done or free_push.

Configuration
REQ-022 GC_WEAR_LEVEL_EN defined: SHALL keep 16-bit saturating per-block erase counts, increment on erase_ack; SCAN ties go to lower erase count, then lower index.
REQ-023 GC_WEAR_LEVEL_EN undefined: no erase counters; ties to lowest index only.

Structure
REQ-024 block_t, gc_state_t, GC_ERASE_CNT_W SHALL live in NVM_pkg.
REQ-025 SHALL use one sub-module, gc_victim_sel, holding best-candidate compare/latch logic for SCAN.

Verification
REQ-026 gc_ini, 61 recover pops -> free_cnt=3, gc_request=1; before gc_start, gc_request stays 1 and FSM stays IDLE.
REQ-027 Invalidate blk 5 x3, blk 9 x7, gc_start -> after 64 SCAN cycles active_blk=9, move_flag=1; move_done_flag, erase_ack -> free_push with free_blk=9, req_done one cycle.
REQ-028 Blk 2 and blk 7 at count 4 -> victim 2; GC_WEAR_LEVEL_EN with blk 2 erased once more -> victim 7.
REQ-029 active_request high 5 cycles during MOVE -> gc_interrupt=1 and move_flag=0 for 5 cycles, then move_flag=1.
REQ-030 Invalidate blk 3 x40 -> count saturates at 32; only open block has invalid pages -> DONE, req_done=1, free_push=0.
REQ-031 RST asserted in ERASE -> all outputs 0 immediately; free_cnt=64 after release.

Source files
------------

// File: rtl/gc_scheduler_pkg.sv
// +----------------------------------------------------------------------------+
// | NVM_pkg : shared types and constants for the GC scheduler slice             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package NVM_pkg;

  localparam int GC_NUM_BLK     = 64;
  localparam int GC_BLK_W       = $clog2(GC_NUM_BLK);
  localparam int GC_ERASE_CNT_W = 16;

  typedef logic [GC_BLK_W-1:0] block_t;

  typedef enum logic [2:0] {
    GC_IDLE  = 3'd0,
    GC_SCAN  = 3'd1,
    GC_MOVE  = 3'd2,
    GC_PAUSE = 3'd3,
    GC_ERASE = 3'd4,
    GC_DONE  = 3'd5
  } gc_state_t;

endpackage

`default_nettype wire

// File: rtl/gc_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | gc_scheduler_if : controller <-> GC scheduler handshake and block bus      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gc_scheduler_if;
  import NVM_pkg::*;

  logic   gc_ini;
  logic   gc_start;
  logic   active_request;
  logic   invalid_flag;
  block_t invalid_blk;
  logic   move_done_flag;
  logic   erase_ack;
  logic   fifo_recover_en;
  block_t recover_blk;

  logic   gc_request;
  logic   gc_interrupt;
  logic   req_done;
  logic   move_flag;
  block_t active_blk;
  logic   erase_flag;
  block_t erase_blk;
  logic   free_push;
  block_t free_blk;

  modport master (
    output gc_ini, gc_start, active_request, invalid_flag, invalid_blk,
           move_done_flag, erase_ack, fifo_recover_en, recover_blk,
    input  gc_request, gc_interrupt, req_done, move_flag, active_blk,
           erase_flag, erase_blk, free_push, free_blk
  );

  modport slave (
    input  gc_ini, gc_start, active_request, invalid_flag, invalid_blk,
           move_done_flag, erase_ack, fifo_recover_en, recover_blk,
    output gc_request, gc_interrupt, req_done, move_flag, active_blk,
           erase_flag, erase_blk, free_push, free_blk
  );

endinterface

`default_nettype wire

// File: rtl/gc_scheduler_victim_sel.sv
// +----------------------------------------------------------------------------+
// | gc_victim_sel : running best-candidate compare/latch for the victim scan   |
// | Optional GC_WEAR_LEVEL_EN breaks count ties by lower erase count.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gc_victim_sel
  import NVM_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             clr,
  input  wire logic             cand_en,
  input  wire logic             cand_ok,
  input  wire block_t           cand_idx,
  input  wire logic [CNT_W-1:0] cand_cnt,
`ifdef GC_WEAR_LEVEL_EN
  input  wire logic [GC_ERASE_CNT_W-1:0] cand_wear,
`endif
  output logic                  next_vld,
  output block_t                next_idx
);

  logic             best_vld_q, best_vld_d;
  block_t           best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic             take;
`ifdef GC_WEAR_LEVEL_EN
  logic [GC_ERASE_CNT_W-1:0] best_wear_q, best_wear_d;
`endif

  // Candidates arrive in ascending index order, so a strict compare keeps ties on the lowest index.
  always_comb begin
    take = cand_en && cand_ok && (!best_vld_q || (cand_cnt > best_cnt_q)
`ifdef GC_WEAR_LEVEL_EN
           || ((cand_cnt == best_cnt_q) && (cand_wear < best_wear_q))
`endif
           );
    best_vld_d = best_vld_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
`ifdef GC_WEAR_LEVEL_EN
    best_wear_d = best_wear_q;
`endif
    if (take) begin
      best_vld_d = 1'b1;
      best_idx_d = cand_idx;
      best_cnt_d = cand_cnt;
`ifdef GC_WEAR_LEVEL_EN
      best_wear_d = cand_wear;
`endif
    end
    if (clr) begin
      best_vld_d = 1'b0;
    end
    next_vld = best_vld_d;
    next_idx = best_idx_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      best_vld_q <= 1'b0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
`ifdef GC_WEAR_LEVEL_EN
      best_wear_q <= '0;
`endif
    end else begin
      best_vld_q <= best_vld_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
`ifdef GC_WEAR_LEVEL_EN
      best_wear_q <= best_wear_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/gc_scheduler.sv
// +----------------------------------------------------------------------------+
// | gc_scheduler : NVM garbage-collection scheduler (scan, move, erase, free)  |
// | Optional GC_WEAR_LEVEL_EN adds per-block erase counts for tie breaking.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gc_scheduler
  import NVM_pkg::*;
#(
  parameter int NUM_BLK    = 64,
  parameter int PG_PER_BLK = 32,
  parameter int FREE_LOW   = 4
) (
  input wire logic      CLK,
  input wire logic      RST,
  gc_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(PG_PER_BLK + 1);
  localparam int FC_W  = $clog2(NUM_BLK + 1);

  gc_state_t        state_q, state_d;
  logic [CNT_W-1:0] inv_cnt_q [NUM_BLK];
  logic [CNT_W-1:0] inv_cnt_d [NUM_BLK];
  logic [NUM_BLK-1:0] free_q, free_d;
  block_t           open_blk_q, open_blk_d;
  block_t           scan_idx_q, scan_idx_d;
  block_t           victim_q, victim_d;
  logic             victim_vld_q, victim_vld_d;
  logic [FC_W-1:0]  free_cnt_q, free_cnt_d;

  logic   gc_request, gc_interrupt, req_done, move_flag, erase_flag, free_push;
  block_t active_blk, erase_blk, free_blk;
  logic   cand_ok, sel_next_vld;
  block_t sel_next_idx;

`ifdef GC_WEAR_LEVEL_EN
  logic [GC_ERASE_CNT_W-1:0] erase_cnt_q [NUM_BLK];
  logic [GC_ERASE_CNT_W-1:0] erase_cnt_d [NUM_BLK];
`endif

  assign cand_ok = !free_q[scan_idx_q] && (scan_idx_q != open_blk_q)
                   && (inv_cnt_q[scan_idx_q] != '0);

  gc_victim_sel #(.CNT_W(CNT_W)) u_victim_sel (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (state_q == GC_IDLE),
    .cand_en  (state_q == GC_SCAN),
    .cand_ok  (cand_ok),
    .cand_idx (scan_idx_q),
    .cand_cnt (inv_cnt_q[scan_idx_q]),
`ifdef GC_WEAR_LEVEL_EN
    .cand_wear(erase_cnt_q[scan_idx_q]),
`endif
    .next_vld (sel_next_vld),
    .next_idx (sel_next_idx)
  );

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    victim_d     = victim_q;
    victim_vld_d = victim_vld_q;
    gc_request   = 1'b0;
    gc_interrupt = 1'b0;
    req_done     = 1'b0;
    move_flag    = 1'b0;
    active_blk   = '0;
    erase_flag   = 1'b0;
    erase_blk    = '0;
    free_push    = 1'b0;
    free_blk     = '0;
    case (state_q)
      GC_IDLE: begin
        gc_request = (free_cnt_q < FC_W'(FREE_LOW));
        if (gc_request && bus.gc_start) begin
          state_d      = GC_SCAN;
          scan_idx_d   = '0;
          victim_vld_d = 1'b0;
        end
      end
      GC_SCAN: begin
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == block_t'(NUM_BLK - 1)) begin
          victim_d     = sel_next_idx;
          victim_vld_d = sel_next_vld;
          state_d      = sel_next_vld ? GC_MOVE : GC_DONE;
        end
      end
      GC_MOVE: begin
        move_flag  = 1'b1;
        active_blk = victim_q;
        if (bus.move_done_flag) begin
          state_d = GC_ERASE;
        end else if (bus.active_request) begin
          state_d = GC_PAUSE;
        end
      end
      GC_PAUSE: begin
        gc_interrupt = 1'b1;
        active_blk   = victim_q;
        if (!bus.active_request) begin
          state_d = GC_MOVE;
        end
      end
      GC_ERASE: begin
        erase_flag = 1'b1;
        erase_blk  = victim_q;
        if (bus.erase_ack) begin
          state_d = GC_DONE;
        end
      end
      GC_DONE: begin
        // An init arriving in the DONE cycle abandons the result entirely.
        req_done     = !bus.gc_ini;
        free_push    = victim_vld_q && !bus.gc_ini;
        free_blk     = free_push ? victim_q : '0;
        victim_vld_d = 1'b0;
        state_d      = GC_IDLE;
      end
      default: state_d = GC_IDLE;
    endcase
    if (bus.gc_ini) begin
      state_d      = GC_IDLE;
      victim_vld_d = 1'b0;
    end
  end

  // Block bookkeeping; a DONE clear overrides a same-cycle invalidate of the victim.
  always_comb begin
    inv_cnt_d  = inv_cnt_q;
    free_d     = free_q;
    open_blk_d = open_blk_q;
    free_cnt_d = free_cnt_q;
    if (bus.invalid_flag && (inv_cnt_q[bus.invalid_blk] != CNT_W'(PG_PER_BLK))) begin
      inv_cnt_d[bus.invalid_blk] = inv_cnt_q[bus.invalid_blk] + 1'b1;
    end
    if (free_push) begin
      inv_cnt_d[victim_q] = '0;
      free_d[victim_q]    = 1'b1;
    end
    if (bus.fifo_recover_en) begin
      free_d[bus.recover_blk] = 1'b0;
      open_blk_d              = bus.recover_blk;
    end
    case ({free_push, bus.fifo_recover_en})
      2'b10: if (free_cnt_q != FC_W'(NUM_BLK)) free_cnt_d = free_cnt_q + 1'b1;
      2'b01: if (free_cnt_q != '0) free_cnt_d = free_cnt_q - 1'b1;
      default: free_cnt_d = free_cnt_q;
    endcase
    if (bus.gc_ini) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        inv_cnt_d[i] = '0;
      end
      free_d     = '1;
      open_blk_d = '0;
      free_cnt_d = FC_W'(NUM_BLK);
    end
  end

`ifdef GC_WEAR_LEVEL_EN
  // Wear history survives gc_ini; only RST clears it.
  always_comb begin
    erase_cnt_d = erase_cnt_q;
    if ((state_q == GC_ERASE) && bus.erase_ack && (erase_cnt_q[victim_q] != '1)) begin
      erase_cnt_d[victim_q] = erase_cnt_q[victim_q] + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        erase_cnt_q[i] <= '0;
      end
    end else begin
      erase_cnt_q <= erase_cnt_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= GC_IDLE;
      for (int i = 0; i < NUM_BLK; i++) begin
        inv_cnt_q[i] <= '0;
      end
      free_q       <= '1;
      open_blk_q   <= '0;
      scan_idx_q   <= '0;
      victim_q     <= '0;
      victim_vld_q <= 1'b0;
      free_cnt_q   <= FC_W'(NUM_BLK);
    end else begin
      state_q      <= state_d;
      inv_cnt_q    <= inv_cnt_d;
      free_q       <= free_d;
      open_blk_q   <= open_blk_d;
      scan_idx_q   <= scan_idx_d;
      victim_q     <= victim_d;
      victim_vld_q <= victim_vld_d;
      free_cnt_q   <= free_cnt_d;
    end
  end

  assign bus.gc_request   = gc_request;
  assign bus.gc_interrupt = gc_interrupt;
  assign bus.req_done     = req_done;
  assign bus.move_flag    = move_flag;
  assign bus.active_blk   = active_blk;
  assign bus.erase_flag   = erase_flag;
  assign bus.erase_blk    = erase_blk;
  assign bus.free_push    = free_push;
  assign bus.free_blk     = free_blk;

endmodule

`default_nettype wire

// File: tb/tb_gc_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_gc_scheduler : self-checking bench for gc_scheduler with a block model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gc_scheduler;
  import NVM_pkg::*;

  localparam int NB = 64;
  localparam int PG = 32;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst;

  gc_scheduler_if bus();

  gc_scheduler #(.NUM_BLK(NB), .PG_PER_BLK(PG), .FREE_LOW(FL)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of block state.
  int m_inv   [NB];
  bit m_free  [NB];
  int m_erase [NB];
  int m_open;
  int m_fc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_ini();
    for (int i = 0; i < NB; i++) begin
      m_inv[i]  = 0;
      m_free[i] = 1'b1;
    end
    m_open = 0;
    m_fc   = NB;
  endtask

  task automatic do_ini();
    bus.gc_ini = 1'b1;
    tick();
    bus.gc_ini = 1'b0;
    model_ini();
  endtask

  task automatic pop(input int b);
    bus.fifo_recover_en = 1'b1;
    bus.recover_blk     = block_t'(b);
    tick();
    bus.fifo_recover_en = 1'b0;
    m_free[b] = 1'b0;
    m_open    = b;
    if (m_fc > 0) m_fc--;
  endtask

  task automatic inval(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      bus.invalid_flag = 1'b1;
      bus.invalid_blk  = block_t'(b);
      tick();
      if (m_inv[b] < PG) m_inv[b]++;
    end
    bus.invalid_flag = 1'b0;
  endtask

  // Fresh init, then 61 pops leaving 3 free blocks; the last pop sets the open block.
  task automatic setup(input int open_b);
    do_ini();
    for (int i = 0; i < 60; i++) pop(i);
    pop(open_b);
  endtask

  function automatic bit elig(input int i);
    return !m_free[i] && (i != m_open) && (m_inv[i] > 0);
  endfunction

  // Highest count; among those the least worn (if enabled); then the lowest index.
  function automatic int model_victim();
    int mx = 0;
    int mw = 32'h7fffffff;
    for (int i = 0; i < NB; i++) if (elig(i) && m_inv[i] > mx) mx = m_inv[i];
    if (mx == 0) return -1;
`ifdef GC_WEAR_LEVEL_EN
    for (int i = 0; i < NB; i++) if (elig(i) && m_inv[i] == mx && m_erase[i] < mw) mw = m_erase[i];
`else
    mw = 0;
    for (int i = 0; i < NB; i++) m_erase[i] = 0;
`endif
    for (int i = 0; i < NB; i++) if (elig(i) && m_inv[i] == mx && m_erase[i] == mw) return i;
    return -1;
  endfunction

  // Pulse gc_start and count cycles until MOVE or DONE becomes visible (-1 on timeout).
  task automatic gc_scan(output int scan_cyc);
    scan_cyc = -1;
    bus.gc_start = 1'b1;
    tick();
    bus.gc_start = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (bus.move_flag || bus.req_done) begin
        scan_cyc = k;
        break;
      end
    end
  endtask

  // From MOVE: relocation done, erase with random latency, capture DONE outputs.
  task automatic gc_finish(input int exp_v, output int ers_blk, output bit done,
                           output bit push, output int fblk, output bit after);
    bus.move_done_flag = 1'b1;
    tick();
    bus.move_done_flag = 1'b0;
    ers_blk = bus.erase_flag ? int'(bus.erase_blk) : -1;
    repeat ($urandom_range(0, 3)) tick();
    bus.erase_ack = 1'b1;
    tick();
    bus.erase_ack = 1'b0;
    done = bus.req_done;
    push = bus.free_push;
    fblk = int'(bus.free_blk);
    tick();
    after = bus.req_done || bus.free_push;
    if (exp_v >= 0) begin
      m_free[exp_v] = 1'b1;
      m_inv[exp_v]  = 0;
      m_erase[exp_v]++;
      if (m_fc < NB) m_fc++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.gc_request, bus.gc_interrupt, bus.req_done, bus.move_flag, bus.active_blk,
         bus.erase_flag, bus.erase_blk, bus.free_push, bus.free_blk} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    tick();
    n_checks++;
    if (bus.gc_request !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_request: got %b expected 0", bus.gc_request);
    end
  endtask

  task automatic test_request();
    do_ini();
    for (int i = 0; i < 60; i++) pop(i);
    n_checks++;
    if (bus.gc_request !== (m_fc < FL)) begin
      n_fail++;
      $display("FAIL request_at_4: got %b expected %b", bus.gc_request, (m_fc < FL));
    end
    pop(60);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({bus.gc_request, bus.move_flag, bus.req_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL request_hold cyc %0d: got %b expected 100", k,
                 {bus.gc_request, bus.move_flag, bus.req_done});
      end
      tick();
    end
  endtask

  task automatic test_basic();
    int sc, eb, fb, v;
    bit dn, ps, af;
    setup(60);
    inval(5, 3);
    inval(9, 7);
    v = model_victim();
    gc_scan(sc);
    n_checks++;
    if (sc !== 64) begin n_fail++; $display("FAIL basic_scan_len: got %0d expected 64", sc); end
    n_checks++;
    if ({bus.move_flag, int'(bus.active_blk)} !== {1'b1, 32'd9}) begin
      n_fail++;
      $display("FAIL basic_victim: got flag %b blk %0d expected 1 9", bus.move_flag, bus.active_blk);
    end
    gc_finish(v, eb, dn, ps, fb, af);
    n_checks++;
    if (eb !== 9) begin n_fail++; $display("FAIL basic_erase_blk: got %0d expected 9", eb); end
    n_checks++;
    if ({dn, ps, fb} !== {1'b1, 1'b1, 32'd9}) begin
      n_fail++;
      $display("FAIL basic_done: got done %b push %b blk %0d expected 1 1 9", dn, ps, fb);
    end
    n_checks++;
    if ({af, bus.gc_request} !== {1'b0, (m_fc < FL)}) begin
      n_fail++;
      $display("FAIL basic_after: got pulse %b req %b expected 0 %b", af, bus.gc_request, (m_fc < FL));
    end
  endtask

  task automatic test_tie();
    int sc, eb, fb, exp_v;
    bit dn, ps, af;
`ifdef GC_WEAR_LEVEL_EN
    setup(60);
    inval(2, 1);
    gc_scan(sc);
    n_checks++;
    if (int'(bus.active_blk) !== 2) begin
      n_fail++;
      $display("FAIL tie_preerase: got %0d expected 2", bus.active_blk);
    end
    gc_finish(2, eb, dn, ps, fb, af);
    exp_v = 7;
`else
    exp_v = 2;
`endif
    setup(60);
    inval(2, 4);
    inval(7, 4);
    gc_scan(sc);
    n_checks++;
    if (int'(bus.active_blk) !== exp_v) begin
      n_fail++;
      $display("FAIL tie_victim: got %0d expected %0d", bus.active_blk, exp_v);
    end
    gc_finish(exp_v, eb, dn, ps, fb, af);
  endtask

  task automatic test_pause();
    int sc, eb, fb;
    bit dn, ps, af;
    setup(60);
    inval(11, 2);
    gc_scan(sc);
    bus.active_request = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({bus.gc_interrupt, bus.move_flag} !== 2'b10) begin
        n_fail++;
        $display("FAIL pause cyc %0d: got int/move %b expected 10", k, {bus.gc_interrupt, bus.move_flag});
      end
    end
    bus.active_request = 1'b0;
    tick();
    n_checks++;
    if ({bus.gc_interrupt, bus.move_flag, int'(bus.active_blk)} !== {2'b01, 32'd11}) begin
      n_fail++;
      $display("FAIL pause_resume: got int/move %b blk %0d expected 01 11",
               {bus.gc_interrupt, bus.move_flag}, bus.active_blk);
    end
    gc_finish(11, eb, dn, ps, fb, af);
    n_checks++;
    if ({ps, fb} !== {1'b1, 32'd11}) begin
      n_fail++;
      $display("FAIL pause_push: got %b %0d expected 1 11", ps, fb);
    end
  endtask

  task automatic test_saturate();
    int sc, eb, fb, v;
    bit dn, ps, af;
    setup(60);
    inval(3, 40);
    inval(2, 32);
    v = model_victim();
    gc_scan(sc);
    n_checks++;
    if (int'(bus.active_blk) !== v) begin
      n_fail++;
      $display("FAIL saturate_victim: got %0d expected %0d", bus.active_blk, v);
    end
    gc_finish(v, eb, dn, ps, fb, af);
  endtask

  task automatic test_open_only();
    int sc;
    setup(3);
    inval(3, 10);
    gc_scan(sc);
    n_checks++;
    if ({sc == 64, bus.req_done, bus.free_push, bus.move_flag} !== 4'b1100) begin
      n_fail++;
      $display("FAIL open_only_done: got len %0d done %b push %b move %b expected 64 1 0 0",
               sc, bus.req_done, bus.free_push, bus.move_flag);
    end
    tick();
    n_checks++;
    if (bus.req_done !== 1'b0) begin n_fail++; $display("FAIL open_only_pulse: got 1 expected 0"); end
  endtask

  task automatic test_ini_abort();
    int bad = 0;
    setup(60);
    inval(4, 5);
    bus.gc_start = 1'b1;
    tick();
    bus.gc_start = 1'b0;
    repeat (10) tick();
    do_ini();
    for (int k = 0; k < 80; k++) begin
      if (bus.req_done || bus.free_push || bus.move_flag || bus.gc_request) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL ini_abort: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_random();
    int sc, eb, fb, v, p;
    bit dn, ps, af;
    for (int it = 0; it < 6; it++) begin
      do_ini();
      for (int k = 0; k < 61; k++) pop($urandom_range(0, NB - 1));
      for (int k = 0; k < 12; k++) inval($urandom_range(0, 15), $urandom_range(1, 6));
      v = model_victim();
      gc_scan(sc);
      n_checks++;
      if (sc !== 64) begin n_fail++; $display("FAIL rand%0d_scan_len: got %0d expected 64", it, sc); end
      if (v >= 0) begin
        n_checks++;
        if ({bus.move_flag, int'(bus.active_blk)} !== {1'b1, v}) begin
          n_fail++;
          $display("FAIL rand%0d_victim: got move %b blk %0d expected 1 %0d", it, bus.move_flag, bus.active_blk, v);
        end
        p = $urandom_range(0, 3);
        bus.active_request = (p != 0);
        for (int k = 0; k < p; k++) begin
          tick();
          n_checks++;
          if (bus.gc_interrupt !== 1'b1) begin n_fail++; $display("FAIL rand%0d_pause: got 0 expected 1", it); end
        end
        bus.active_request = 1'b0;
        if (p != 0) tick();
        gc_finish(v, eb, dn, ps, fb, af);
        n_checks++;
        if ({eb, dn, ps, fb} !== {v, 1'b1, 1'b1, v}) begin
          n_fail++;
          $display("FAIL rand%0d_done: got erase %0d done %b push %b blk %0d expected %0d 1 1 %0d",
                   it, eb, dn, ps, fb, v, v);
        end
      end else begin
        n_checks++;
        if ({bus.req_done, bus.free_push} !== 2'b10) begin
          n_fail++;
          $display("FAIL rand%0d_empty: got done/push %b expected 10", it, {bus.req_done, bus.free_push});
        end
        tick();
      end
    end
  endtask

  task automatic test_rst_erase();
    int sc, bad = 0;
    setup(60);
    inval(6, 5);
    gc_scan(sc);
    bus.move_done_flag = 1'b1;
    tick();
    bus.move_done_flag = 1'b0;
    n_checks++;
    if ({bus.erase_flag, int'(bus.erase_blk)} !== {1'b1, 32'd6}) begin
      n_fail++;
      $display("FAIL rst_pre_erase: got %b %0d expected 1 6", bus.erase_flag, bus.erase_blk);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.gc_request, bus.gc_interrupt, bus.req_done, bus.move_flag, bus.active_blk,
         bus.erase_flag, bus.erase_blk, bus.free_push, bus.free_blk} !== 24'd0) begin
      n_fail++;
      $display("FAIL rst_async: got nonzero outputs expected all 0");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_ini();
    for (int i = 0; i < NB; i++) m_erase[i] = 0;
    bus.erase_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (bus.req_done || bus.free_push || bus.erase_flag) bad++;
      tick();
    end
    bus.erase_ack = 1'b0;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rst_abandon: got %0d active cycles expected 0", bad); end
    for (int i = 0; i < 60; i++) pop(i);
    n_checks++;
    if (bus.gc_request !== 1'b0) begin n_fail++; $display("FAIL rst_fc_60: got 1 expected 0"); end
    pop(60);
    n_checks++;
    if (bus.gc_request !== 1'b1) begin n_fail++; $display("FAIL rst_fc_61: got 0 expected 1"); end
  endtask

  initial begin
    bus.gc_ini = 1'b0; bus.gc_start = 1'b0; bus.active_request = 1'b0;
    bus.invalid_flag = 1'b0; bus.invalid_blk = '0; bus.move_done_flag = 1'b0;
    bus.erase_ack = 1'b0; bus.fifo_recover_en = 1'b0; bus.recover_blk = '0;
    for (int i = 0; i < NB; i++) m_erase[i] = 0;
    model_ini();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_request();
    test_basic();
    test_tie();
    test_pause();
    test_saturate();
    test_open_only();
    test_ini_abort();
    test_random();
    test_rst_erase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
